// File: rtl/neurochip_pkg.sv
// Shared constants for neurochip configuration segments: field offsets, widths and the neuron state enum.
package neurochip_pkg;

  localparam int N_IN_DEF    = 4;
  localparam int W_WIDTH_DEF = 4;
  localparam int V_WIDTH_DEF = 8;

  localparam int EN_BIT     = 0;
  localparam int REFR_LSB   = 1;
  localparam int REFR_W     = 3;
  localparam int LEAK_LSB   = 4;
  localparam int LEAK_W     = 4;
  localparam int THRESH_LSB = 8;

  function automatic int cfg_bits(input int n_in, input int w_width, input int v_width);
    return n_in * w_width + v_width + 8;
  endfunction

  localparam int CFG_BITS = cfg_bits(N_IN_DEF, W_WIDTH_DEF, V_WIDTH_DEF);

  // Weights sit above the threshold, w0 in the topmost slot.
  function automatic int W_LSB(input int i, input int n_in, input int w_width, input int v_width);
    return THRESH_LSB + v_width + (n_in - 1 - i) * w_width;
  endfunction

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    INTEGRATE  = 2'd1,
    REFRACTORY = 2'd2
  } state_e;

endpackage

// File: rtl/cfg_shift_segment.sv
// One segment of the serial configuration chain: shifts MSB-ward while config_en is high,
// bs_out is the current MSB so segments can be daisy-chained.
module cfg_shift_segment #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           config_en,
  input  logic           bs_in,
  output logic           bs_out,
  output logic [LEN-1:0] cfg
);

  logic [LEN-1:0] cfg_q;
  logic [LEN-1:0] cfg_d;

  always_comb begin
    cfg_d = cfg_q;
    if (config_en) cfg_d = {cfg_q[LEN-2:0], bs_in};
  end

  always_ff @(posedge clk) begin
    if (reset) cfg_q <= '0;
    else       cfg_q <= cfg_d;
  end

  assign cfg    = cfg_q;
  assign bs_out = cfg_q[LEN-1];

endmodule

// File: rtl/lif_neuron_cell.sv
// Leaky integrate-and-fire neuron: weighted spike sum minus leak, clamped, fires at threshold,
// then sits out a programmable refractory period. Configured through its own chain segment.
module lif_neuron_cell
  import neurochip_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               config_en,
  input  logic               bs_in,
  output logic               bs_out,
  input  logic [N_IN-1:0]    spike_in,
  output logic               spike_out,
  output logic [V_WIDTH-1:0] membrane
);

  localparam int SEG_BITS = cfg_bits(N_IN, W_WIDTH, V_WIDTH);
  localparam int S_W      = V_WIDTH + W_WIDTH + $clog2(N_IN) + 2;

  logic [SEG_BITS-1:0] cfg;

  cfg_shift_segment #(.LEN(SEG_BITS)) u_cfg_seg (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .cfg       (cfg)
  );

  logic [V_WIDTH-1:0] thresh;
  logic [LEAK_W-1:0]  leak;
  logic [REFR_W-1:0]  refr;
  logic               en;

  assign thresh = cfg[THRESH_LSB +: V_WIDTH];
  assign leak   = cfg[LEAK_LSB +: LEAK_W];
  assign refr   = cfg[REFR_LSB +: REFR_W];
  assign en     = cfg[EN_BIT];

  state_e             state_q, state_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic [REFR_W-1:0]  rcnt_q, rcnt_d;
  logic               spike_q, spike_d;

  // Datapath: two's-complement accumulator wide enough that neither end can wrap.
  logic [W_WIDTH-1:0] w_sel;
  logic [S_W-1:0]     acc;
  logic [V_WIDTH-1:0] v_clamp;
  logic               fire;
  logic               hold_off;

  always_comb begin
    w_sel = '0;
    acc   = {{(S_W-V_WIDTH){1'b0}}, v_q};
    for (int i = 0; i < N_IN; i++) begin
      w_sel = cfg[W_LSB(i, N_IN, W_WIDTH, V_WIDTH) +: W_WIDTH];
      if (spike_in[i]) acc = acc + {{(S_W-W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel};
    end
    acc = acc - {{(S_W-LEAK_W){1'b0}}, leak};
  end

  always_comb begin
    v_clamp = acc[V_WIDTH-1:0];
    if (acc[S_W-1])                  v_clamp = '0;
    else if (|acc[S_W-2:V_WIDTH])    v_clamp = '1;
  end

  assign fire     = (thresh != '0) && (v_clamp >= thresh);
  assign hold_off = config_en || !en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISABLED;
      v_q     <= '0;
      rcnt_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      rcnt_q  <= rcnt_d;
      spike_q <= spike_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (hold_off) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED, INTEGRATE: state_d = (fire && refr != '0) ? REFRACTORY : INTEGRATE;
        REFRACTORY:          if (rcnt_q <= REFR_W'(1)) state_d = INTEGRATE;
        default:             state_d = DISABLED;
      endcase
    end
  end

  // DISABLED integrates too once enabled, so a new configuration acts on its first free edge.
  always_comb begin
    v_d     = '0;
    spike_d = 1'b0;
    rcnt_d  = '0;
    if (!hold_off) begin
      case (state_q)
        DISABLED, INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            rcnt_d  = refr;
          end else begin
            v_d = v_clamp;
          end
        end
        REFRACTORY: if (rcnt_q != '0) rcnt_d = rcnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign spike_out = spike_q;
  assign membrane  = v_q;

endmodule
